// File: rtl/ret_addr_stack_if.sv
// ----------------------------------------------------------------------------
// ret_addr_stack_if
//   Request/response bundle for the return-address stack.
//   master : drives push (JAL), pop (JS), flush and push_data (PC+4);
//            observes top_data, sp, count and the status flags.
//   slave  : the stack itself.
//   DATA_W and DEPTH must match the parameters of the attached stack.
// ----------------------------------------------------------------------------
interface ret_addr_stack_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              push;
    logic              pop;
    logic              flush;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] top_data;
    logic [31:0]       sp;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;
    logic              err;

    modport master (
        output push, pop, flush, push_data,
        input  top_data, sp, count, empty, full, overflow, underflow, err
    );

    modport slave (
        input  push, pop, flush, push_data,
        output top_data, sp, count, empty, full, overflow, underflow, err
    );
endinterface

// File: rtl/ret_addr_stack.sv
// ----------------------------------------------------------------------------
// ret_addr_stack
//   Clocked return-address stack. JAL pushes PC+4, JS pops and reads the
//   jump target from top_data in the same cycle. Also reports a byte-address
//   stack pointer compatible with the legacy RAM window (entry 0 at BASE_ADDR).
//
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous, active-high reset
//     bus    slave modport of ret_addr_stack_if:
//       push/pop/flush/push_data  requests (priority flush > push&pop > push > pop)
//       top_data  combinational top entry (0 when empty)
//       sp        BASE_ADDR + 4*top index (BASE_ADDR when empty)
//       count/empty/full          occupancy
//       overflow/underflow        one-cycle registered pulses
//       err                       sticky, cleared by reset or flush
// ----------------------------------------------------------------------------
module ret_addr_stack #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0058,
    parameter bit          WRAP_MODE = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    ret_addr_stack_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  count;
    logic              overflow_q;
    logic              underflow_q;
    logic              err_q;
    logic              is_empty;
    logic              is_full;

    // DEPTH is a power of two, so the pointer wraps modulo DEPTH for free.
    assign top_idx  = wr_ptr - PTR_W'(1);
    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem         <= '{default: '0};
            wr_ptr      <= '0;
            count       <= '0;
            err_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            if (bus.flush) begin
                // Storage is intentionally left intact; count=0 hides it.
                wr_ptr <= '0;
                count  <= '0;
                err_q  <= 1'b0;
            end else if (bus.push && bus.pop) begin
                if (!is_empty) begin
                    // Tail call: replace the top entry in place.
                    mem[top_idx] <= bus.push_data;
                end else begin
                    // Pop half is invalid; push half still proceeds.
                    mem[wr_ptr] <= bus.push_data;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                    count       <= CNT_W'(1);
                    underflow_q <= 1'b1;
                    err_q       <= 1'b1;
                end
            end else if (bus.push) begin
                if (!is_full) begin
                    mem[wr_ptr] <= bus.push_data;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                    count       <= count + CNT_W'(1);
                end else begin
                    overflow_q <= 1'b1;
                    err_q      <= 1'b1;
                    if (WRAP_MODE) begin
                        // Circular: the slot at wr_ptr holds the oldest entry.
                        mem[wr_ptr] <= bus.push_data;
                        wr_ptr      <= wr_ptr + PTR_W'(1);
                    end
                end
            end else if (bus.pop) begin
                if (!is_empty) begin
                    wr_ptr <= top_idx;
                    count  <= count - CNT_W'(1);
                end else begin
                    underflow_q <= 1'b1;
                    err_q       <= 1'b1;
                end
            end
        end
    end

    assign bus.top_data  = is_empty ? '0 : mem[top_idx];
    assign bus.sp        = is_empty ? BASE_ADDR : (BASE_ADDR + (32'(top_idx) << 2));
    assign bus.count     = count;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_ret_addr_stack.sv
// ----------------------------------------------------------------------------
// tb_ret_addr_stack
//   Two DEPTH=4 stacks (WRAP_MODE 0 and 1) share one request stream. The
//   driver applies a request each cycle and queues the state the reference
//   model predicts after the next edge; the monitor pops and compares after
//   every clock edge and after every asynchronous reset assertion.
// ----------------------------------------------------------------------------
module tb_ret_addr_stack;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] top;
        logic [31:0] sp;
        logic [2:0]  count;
        logic        empty;
        logic        full;
        logic        ov;
        logic        un;
        logic        err;
    } obs_t;

    typedef struct packed {
        obs_t w0;
        obs_t w1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] push_data = '0;

    always #5 clk = ~clk;

    ret_addr_stack_if #(.DATA_W(32), .DEPTH(DEPTH)) if0 ();
    ret_addr_stack_if #(.DATA_W(32), .DEPTH(DEPTH)) if1 ();

    assign if0.push = push;  assign if0.pop = pop;
    assign if0.flush = flush; assign if0.push_data = push_data;
    assign if1.push = push;  assign if1.pop = pop;
    assign if1.flush = flush; assign if1.push_data = push_data;

    ret_addr_stack #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h58), .WRAP_MODE(1'b0))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    ret_addr_stack #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h58), .WRAP_MODE(1'b1))
        dut1 (.clk(clk), .reset(reset), .bus(if1));

    // ---------------- reference model ----------------
    // Each stack is a queue of live return addresses (oldest first); pos is
    // the slot where the next entry would be placed, used only for sp.
    logic [31:0] stk0[$];
    logic [31:0] stk1[$];
    int          pos[2];
    bit          merr[2];
    bit          mov[2];
    bit          mun[2];

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   started = 0;
    bit   done = 0;

    function automatic int q_size(int m);
        return (m == 0) ? stk0.size() : stk1.size();
    endfunction

    function automatic logic [31:0] q_top(int m);
        return (m == 0) ? stk0[stk0.size()-1] : stk1[stk1.size()-1];
    endfunction

    task automatic q_push(int m, logic [31:0] d);
        if (m == 0) stk0.push_back(d); else stk1.push_back(d);
    endtask

    task automatic q_drop_top(int m);
        if (m == 0) void'(stk0.pop_back()); else void'(stk1.pop_back());
    endtask

    task automatic q_drop_oldest(int m);
        if (m == 0) void'(stk0.pop_front()); else void'(stk1.pop_front());
    endtask

    task automatic model_reset();
        stk0.delete();
        stk1.delete();
        for (int m = 0; m < 2; m++) begin
            pos[m] = 0; merr[m] = 0; mov[m] = 0; mun[m] = 0;
        end
    endtask

    task automatic model_step(int m, bit p, bit o, bit f, logic [31:0] d);
        mov[m] = 0;
        mun[m] = 0;
        if (f) begin
            if (m == 0) stk0.delete(); else stk1.delete();
            pos[m] = 0;
            merr[m] = 0;
        end else if (p && o) begin
            if (q_size(m) > 0) begin
                q_drop_top(m);
                q_push(m, d);
            end else begin
                mun[m] = 1; merr[m] = 1;
                q_push(m, d);
                pos[m] = (pos[m] + 1) % DEPTH;
            end
        end else if (p) begin
            if (q_size(m) < DEPTH) begin
                q_push(m, d);
                pos[m] = (pos[m] + 1) % DEPTH;
            end else begin
                mov[m] = 1; merr[m] = 1;
                if (m == 1) begin
                    q_drop_oldest(m);
                    q_push(m, d);
                    pos[m] = (pos[m] + 1) % DEPTH;
                end
            end
        end else if (o) begin
            if (q_size(m) > 0) begin
                q_drop_top(m);
                pos[m] = (pos[m] + DEPTH - 1) % DEPTH;
            end else begin
                mun[m] = 1; merr[m] = 1;
            end
        end
    endtask

    function automatic obs_t model_obs(int m);
        obs_t o;
        int   n;
        n       = q_size(m);
        o.top   = (n > 0) ? q_top(m) : 32'h0;
        o.sp    = (n > 0) ? 32'h58 + 32'(4 * ((pos[m] + DEPTH - 1) % DEPTH)) : 32'h58;
        o.count = 3'(n);
        o.empty = (n == 0);
        o.full  = (n == DEPTH);
        o.ov    = mov[m];
        o.un    = mun[m];
        o.err   = merr[m];
        return o;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.w0 = model_obs(0);
        e.w1 = model_obs(1);
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(bit p, bit o, bit f, logic [31:0] d);
        @(negedge clk);
        reset     = 1'b0;
        push      = p;
        pop       = o;
        flush     = f;
        push_data = d;
        model_step(0, p, o, f, d);
        model_step(1, p, o, f, d);
        q.push_back(model_exp());
    endtask

    // Reset lands mid-cycle; one expectation for the reset edge itself and
    // one for the clock edge that follows while reset is still held.
    task automatic do_reset();
        @(negedge clk);
        #2;
        started = 1;
        model_reset();
        q.push_back(model_exp());
        q.push_back(model_exp());
        reset = 1'b1;
    endtask

    // ---------------- monitor ----------------
    function automatic obs_t dut_obs(int m);
        obs_t o;
        if (m == 0) begin
            o = '{if0.top_data, if0.sp, if0.count, if0.empty, if0.full,
                  if0.overflow, if0.underflow, if0.err};
        end else begin
            o = '{if1.top_data, if1.sp, if1.count, if1.empty, if1.full,
                  if1.overflow, if1.underflow, if1.err};
        end
        return o;
    endfunction

    task automatic chk(int m, string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL w%0d.%s at %0t: got %h expected %h", m, name, $time, act, exp);
        end
    endtask

    task automatic compare(int m, obs_t e);
        obs_t a;
        a = dut_obs(m);
        chk(m, "top_data",  a.top, e.top);
        chk(m, "sp",        a.sp, e.sp);
        chk(m, "count",     32'(a.count), 32'(e.count));
        chk(m, "empty",     32'(a.empty), 32'(e.empty));
        chk(m, "full",      32'(a.full), 32'(e.full));
        chk(m, "overflow",  32'(a.ov), 32'(e.ov));
        chk(m, "underflow", 32'(a.un), 32'(e.un));
        chk(m, "err",       32'(a.err), 32'(e.err));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare(0, e.w0);
                compare(1, e.w1);
            end else if (started && !done) begin
                total++;
                bad++;
                $display("FAIL noexp at %0t: got empty queue expected an entry", $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        do_reset();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // basic LIFO order
        cycle(1, 0, 0, 32'h100);
        cycle(1, 0, 0, 32'h104);
        cycle(1, 0, 0, 32'h108);
        repeat (3) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // fill past capacity: reject vs circular overwrite
        cycle(0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) cycle(1, 0, 0, 32'(i * 16));
        cycle(0, 0, 0, 0);
        repeat (4) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // underflow, flush clears err, tail-call replace
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 32'h1000);
        cycle(1, 0, 0, 32'h2000);
        cycle(1, 1, 0, 32'hAA);
        cycle(0, 0, 0, 0);

        // push&pop on empty: underflow plus a normal push
        cycle(0, 0, 1, 0);
        cycle(1, 1, 0, 32'hBB);
        cycle(0, 0, 0, 0);

        // async reset with count=3, then first push lands at BASE_ADDR
        cycle(1, 0, 0, 32'h200);
        cycle(1, 0, 0, 32'h204);
        do_reset();
        cycle(1, 0, 0, 32'h300);
        cycle(0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            r = $urandom_range(0, 99);
            if (r < 3)       cycle(0, 0, 1, 0);
            else if (r < 13) cycle(1, 1, 0, $urandom & 32'hFFFF_FFFC);
            else if (r < 55) cycle(1, 0, 0, $urandom & 32'hFFFF_FFFC);
            else if (r < 95) cycle(0, 1, 0, 0);
            else             cycle(0, 0, 0, 0);
        end

        done = 1;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
